fsfifo_wr_arb: RTL and testbench

Round-robin burst arbiter that shares the single write port of one fsfifo instance among N_REQ producers. Sits directly in front of the FIFO write side, same clock domain.
- Grants one requester at a time and holds the grant for a burst.
- Forwards accepted beats as FIFO write strobes.
- Back-pressures every requester through a per-port ready.

---
 rtl/fsfifo_wr_arb_pkg.sv | 14 +
 rtl/fsfifo_wr_arb_rr_pick.sv | 35 +++
 rtl/fsfifo_wr_arb.sv | 135 +++++++++++++
 tb/tb_fsfifo_wr_arb.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fsfifo_wr_arb_pkg.sv
// Shared types and constants for the fsfifo write-port arbiter.
// Requester indices are sized for the largest supported requester count.
package fsfifo_wr_arb_pkg;

  localparam int unsigned N_REQ_MAX = 8;
  localparam int unsigned IDX_W     = $clog2(N_REQ_MAX);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [0:0]       state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_BURST = 1'b1;

endpackage

// File: rtl/fsfifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from ptr_i+1 (modulo N_REQ), returned as one-hot plus its index.
module fsfifo_wr_arb_rr_pick
  import fsfifo_wr_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  idx_t             ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output idx_t             idx_o,
  output logic             any_o
);

  idx_t k;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      k = IDX_W'((32'(ptr_i) + i) % N_REQ);
      if (!found && |(req_i & (N_REQ'(1) << k))) begin
        found   = 1'b1;
        grant_o = N_REQ'(1) << k;
        idx_o   = k;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/fsfifo_wr_arb.sv
// Round-robin burst arbiter sharing one fsfifo write port among N_REQ producers.
// One grant at a time, held for up to BURST_MAX beats; 1-cycle bubble between bursts.
module fsfifo_wr_arb
  import fsfifo_wr_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ-1:0]         req_last_i,
  input  logic [N_REQ*WIDTH-1:0]   req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic                     fifo_full_i,
  input  logic [$clog2(DEPTH):0]   fifo_filled_i,
  output logic                     fifo_wr_o,
  output logic [WIDTH-1:0]         fifo_wr_data_o,
  output logic [N_REQ-1:0]         grant_o,
  output logic                     busy_o
);

  localparam int unsigned CNT_W  = $clog2(BURST_MAX + 1);
  localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  idx_t               gidx_q, gidx_d;
  idx_t               rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   pick_grant;
  idx_t               pick_idx;
  logic               pick_any;

  logic               busy, g_valid, g_last, accept, cap, leave;
  logic [CNT_W-1:0]   cnt_inc;

  fsfifo_wr_arb_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .ptr_i   (rr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign busy    = (state_q == ST_BURST);
  assign g_valid = |(req_valid_i & grant_q);
  assign g_last  = |(req_last_i & grant_q);
  assign accept  = busy && g_valid && !fifo_full_i && !reset_i;
  assign cnt_inc = cnt_q + 1'b1;
  assign cap     = (cnt_inc == CNT_W'(BURST_MAX));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    leave   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any && !fifo_full_i) begin
          state_d = ST_BURST;
          grant_d = pick_grant;
          gidx_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        // A full FIFO freezes the burst: no count, no exit, even on abandon.
        if (!fifo_full_i) begin
          if (!g_valid) begin
            leave = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            leave = g_last || cap;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (leave) begin
      state_d = ST_IDLE;
      grant_d = '0;
      rr_d    = gidx_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o    = (busy && !fifo_full_i && !reset_i) ? grant_q : '0;
  assign fifo_wr_o      = accept;
  assign fifo_wr_data_o = busy ? req_data_i[32'(gidx_q)*WIDTH +: WIDTH] : '0;
  assign grant_o        = grant_q;
  assign busy_o         = busy;

  // Occupancy only feeds the consistency check below.
  logic unused_filled;
  assign unused_filled = ^fifo_filled_i;

`ifdef FORMAL
  a_full_consistent: assert property (@(posedge clk_i)
    fifo_full_i == (fifo_filled_i == FILL_W'(DEPTH)));
  a_grant_onehot: assert property (@(posedge clk_i) $onehot0(grant_q));
  a_ready_onehot: assert property (@(posedge clk_i) $onehot0(req_ready_o));
  a_busy_grant:   assert property (@(posedge clk_i) busy_o == |grant_q);
  a_wr_not_full:  assert property (@(posedge clk_i) fifo_wr_o |-> !fifo_full_i);
  a_cnt_bound:    assert property (@(posedge clk_i) cnt_q <= CNT_W'(BURST_MAX));
  for (genvar g = 0; g < N_REQ; g++) begin : g_stable
    a_req_stable: assert property (@(posedge clk_i) disable iff (reset_i)
      (req_valid_i[g] && !req_ready_o[g]) |=>
      (!req_valid_i[g] || ($stable(req_data_i[g*WIDTH +: WIDTH]) && $stable(req_last_i[g]))));
  end
`endif

endmodule

// File: tb/tb_fsfifo_wr_arb.sv
// Directed self-checking bench for fsfifo_wr_arb: a 4-requester default build
// and a 2-requester BURST_MAX=1 build sharing one clock and reset.
module tb_fsfifo_wr_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default build
  logic [3:0]   valid, last, ready, grant;
  logic [127:0] data;
  logic         full, wr, busy;
  logic [4:0]   filled;
  logic [31:0]  wdata;

  fsfifo_wr_arb #(
    .N_REQ(4), .WIDTH(32), .DEPTH(16), .BURST_MAX(4)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(valid), .req_last_i(last), .req_data_i(data), .req_ready_o(ready),
    .fifo_full_i(full), .fifo_filled_i(filled),
    .fifo_wr_o(wr), .fifo_wr_data_o(wdata), .grant_o(grant), .busy_o(busy)
  );

  // BURST_MAX=1 build
  logic [1:0]  valid2, last2, ready2, grant2;
  logic [15:0] data2;
  logic        wr2, busy2;
  logic [2:0]  filled2;
  logic [7:0]  wdata2;

  fsfifo_wr_arb #(
    .N_REQ(2), .WIDTH(8), .DEPTH(4), .BURST_MAX(1)
  ) dut2 (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(valid2), .req_last_i(last2), .req_data_i(data2), .req_ready_o(ready2),
    .fifo_full_i(1'b0), .fifo_filled_i(filled2),
    .fifo_wr_o(wr2), .fifo_wr_data_o(wdata2), .grant_o(grant2), .busy_o(busy2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [31:0] v);
    data[k*32 +: 32] = v;
  endtask

  initial begin
    rst = 1'b1; valid = 4'b1111; last = '0; data = '0; full = 1'b0; filled = '0;
    valid2 = '0; last2 = '0; data2 = 16'hB1A0; filled2 = '0;
    cyc(); cyc();
    #1;
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_busy",  64'(busy),  64'h0);
    check("rst_ready", 64'(ready), 64'h0);
    check("rst_wr",    64'(wr),    64'h0);

    // Single requester: req1 sends A,B,C with last on C.
    rst = 1'b0; valid = 4'b0010; set_data(1, 32'hAAAA_0001);
    #1;
    check("t1_idle_grant", 64'(grant), 64'h0);
    check("t1_idle_ready", 64'(ready), 64'h0);
    cyc(); #1;
    check("t1_grant", 64'(grant), 64'h2);
    check("t1_busy",  64'(busy),  64'h1);
    check("t1_ready", 64'(ready), 64'h2);
    check("t1_wr_a",  64'(wr),    64'h1);
    check("t1_dat_a", 64'(wdata), 64'hAAAA_0001);
    cyc(); set_data(1, 32'hBBBB_0002); #1;
    check("t1_wr_b",  64'(wr),    64'h1);
    check("t1_dat_b", 64'(wdata), 64'hBBBB_0002);
    cyc(); set_data(1, 32'hCCCC_0003); last = 4'b0010; #1;
    check("t1_wr_c",  64'(wr),    64'h1);
    check("t1_dat_c", 64'(wdata), 64'hCCCC_0003);
    cyc(); valid = '0; last = '0; #1;
    check("t1_end_grant", 64'(grant), 64'h0);
    check("t1_end_busy",  64'(busy),  64'h0);
    check("t1_end_wr",    64'(wr),    64'h0);

    // Fairness from reset: 0,1,2,3,0 with four-beat caps and a bubble between.
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int k = 0; k < 4; k++) set_data(k, 32'hD000_0000 + 32'(k));
    valid = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      #1;
      check($sformatf("fair%0d_idle", b), 64'(grant), 64'h0);
      for (int j = 0; j < 4; j++) begin
        cyc(); #1;
        check($sformatf("fair%0d_grant%0d", b, j), 64'(grant), 64'(4'b0001 << (b % 4)));
        check($sformatf("fair%0d_wr%0d", b, j), 64'(wr), 64'h1);
        check($sformatf("fair%0d_dat%0d", b, j), 64'(wdata), 64'h0D000_0000 + 64'(b % 4));
      end
      cyc();
    end
    valid = '0;
    #1;
    check("fair_done_busy", 64'(busy), 64'h0);

    // Full stall on req2 after two beats; count must not advance while full.
    valid = 4'b0100; set_data(2, 32'hE000_0001);
    cyc(); #1;
    check("st_grant", 64'(grant), 64'h4);
    check("st_dat1",  64'(wdata), 64'hE000_0001);
    cyc(); set_data(2, 32'hE000_0002); #1;
    check("st_wr2",   64'(wr),    64'h1);
    cyc(); set_data(2, 32'hE000_0003); full = 1'b1; filled = 5'd16; #1;
    check("st_full_ready", 64'(ready), 64'h0);
    check("st_full_wr",    64'(wr),    64'h0);
    check("st_full_grant", 64'(grant), 64'h4);
    cyc(); #1;
    check("st_full2_wr",    64'(wr),    64'h0);
    check("st_full2_grant", 64'(grant), 64'h4);
    cyc(); full = 1'b0; filled = 5'd15; #1;
    check("st_pop_ready", 64'(ready), 64'h4);
    check("st_pop_wr",    64'(wr),    64'h1);
    check("st_pop_dat",   64'(wdata), 64'hE000_0003);
    cyc(); set_data(2, 32'hE000_0004); #1;
    check("st_b4_grant", 64'(grant), 64'h4);
    check("st_b4_dat",   64'(wdata), 64'hE000_0004);
    cyc(); valid = '0; #1;
    check("st_end_grant", 64'(grant), 64'h0);

    // Abandon: req3 writes one beat, then drops valid.
    valid = 4'b1000; set_data(3, 32'hF000_0001);
    cyc(); #1;
    check("ab_grant", 64'(grant), 64'h8);
    check("ab_wr",    64'(wr),    64'h1);
    cyc(); valid = '0; #1;
    check("ab_drop_wr",    64'(wr),    64'h0);
    check("ab_drop_grant", 64'(grant), 64'h8);
    cyc(); valid = 4'b1001; #1;
    check("ab_exit_grant", 64'(grant), 64'h0);
    check("ab_exit_busy",  64'(busy),  64'h0);
    cyc(); #1;
    check("ab_next_grant", 64'(grant), 64'h1);
    valid = '0;
    cyc(); cyc(); #1;
    check("ab_idle", 64'(grant), 64'h0);

    // Reset mid-burst on req0 after two beats; rr pointer returns to 3.
    valid = 4'b0001;
    cyc(); #1;
    check("rs_grant", 64'(grant), 64'h1);
    cyc(); #1;
    check("rs_wr2", 64'(wr), 64'h1);
    cyc(); rst = 1'b1; #1;
    check("rs_ready", 64'(ready), 64'h0);
    check("rs_wr",    64'(wr),    64'h0);
    cyc(); #1;
    check("rs_grant0", 64'(grant), 64'h0);
    check("rs_busy0",  64'(busy),  64'h0);
    rst = 1'b0; valid = 4'b0011;
    cyc(); #1;
    check("rs_regrant", 64'(grant), 64'h1);
    valid = '0;
    cyc(); cyc();

    // BURST_MAX=1 build: alternating single-beat grants with bubbles.
    valid2 = 2'b11;
    for (int b = 0; b < 4; b++) begin
      #1;
      check($sformatf("bm1_idle%0d", b), 64'(grant2), 64'h0);
      cyc(); #1;
      check($sformatf("bm1_grant%0d", b), 64'(grant2), 64'(2'b01 << (b % 2)));
      check($sformatf("bm1_wr%0d", b), 64'(wr2), 64'h1);
      check($sformatf("bm1_dat%0d", b), 64'(wdata2), (b % 2 == 0) ? 64'hA0 : 64'hB1);
      cyc();
    end
    valid2 = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
